// File: rtl/alarm_interval_timer.sv
// -----------------------------------------------------------------------------
// alarm_interval_timer
//
// Reads one of the four alarm intervals from the time-parameter register block
// and counts it down in whole seconds.
//
// Operation:
//   - A start_timer request latches interval_sel into the registered `interval`
//     select. The following LOAD cycle captures the 4-bit `value` that the
//     parameter block returns.
//   - The block then counts that value down once per second. `expired` pulses
//     for one cycle when the count completes.
//   - A start_timer request arriving while the block is busy restarts it.
//
// The block also owns the one-second prescaler. It exports the prescaler wrap
// as one_hz_enable for the LED and siren blink logic.
//
// Parameters:
//   ONE_HZ_DIV  clock cycles per one-second tick (>= 2)
//   PRESC_W     prescaler width, 2**PRESC_W >= ONE_HZ_DIV
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   start_timer    one-cycle start/restart request
//   interval_sel   requested interval: 00 ARM, 01 DRIVER, 10 PASSENGER,
//                  11 ALARM_ON
//   interval       registered select driven to the parameter block
//   value          interval length in seconds from the parameter block
//   expired        one-cycle pulse when the countdown completes
//   busy           high whenever the timer is not idle
//   remaining      current countdown value in seconds
//   one_hz_enable  one-cycle pulse on each prescaler wrap while counting
// -----------------------------------------------------------------------------
module alarm_interval_timer #(
  parameter int unsigned ONE_HZ_DIV = 10,
  parameter int unsigned PRESC_W    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval_sel,
  output logic [1:0] interval,
  input  logic [3:0] value,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining,
  output logic       one_hz_enable
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_EXPIRE
  } state_t;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(ONE_HZ_DIV - 1);

  state_t             state_q, state_d;
  logic [1:0]         interval_q, interval_d;
  logic [3:0]         counter_q, counter_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;

  // A one-second tick exists only while counting.
  assign tick = (state_q == S_COUNT) && (presc_q == PRESC_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d    = state_q;
    interval_d = interval_q;
    counter_d  = counter_q;
    presc_d    = presc_q;

    if (start_timer) begin
      // A start or restart request overrides everything else in the current
      // state. A coincident tick decrement or a pending return to idle is
      // dropped. The counter and prescaler are reloaded in LOAD.
      interval_d = interval_sel;
      state_d    = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = '0;
        end
        S_LOAD: begin
          // `interval` has been stable for a full cycle, so `value` is valid.
          counter_d = value;
          presc_d   = '0;
          state_d   = (value == 4'd0) ? S_EXPIRE : S_COUNT;
        end
        S_COUNT: begin
          if (tick) begin
            presc_d = '0;
            if (counter_q != 4'd0) begin
              counter_d = counter_q - 4'd1;
            end
            if (counter_q == 4'd1) begin
              state_d = S_EXPIRE;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
        S_EXPIRE: begin
          counter_d = '0;
          presc_d   = '0;
          state_d   = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      interval_q <= 2'b00;
      counter_q  <= 4'd0;
      presc_q    <= '0;
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      counter_q  <= counter_d;
      presc_q    <= presc_d;
    end
  end

  // Every output is decoded from registers only. Reset therefore clears the
  // outputs immediately.
  assign interval      = interval_q;
  assign expired       = (state_q == S_EXPIRE);
  assign busy          = (state_q != S_IDLE);
  assign remaining     = counter_q;
  assign one_hz_enable = tick;

endmodule

// File: tb/tb_alarm_interval_timer.sv
module tb_alarm_interval_timer;

  localparam int DIV = 10;

  logic       clock;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval_sel;
  logic [1:0] interval;
  logic [3:0] value;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;
  logic       one_hz_enable;

  // Parameter-block model: combinational lookup on the registered select.
  logic [3:0] param_mem [4];
  assign value = param_mem[interval];

  int tests;
  int fails;

  alarm_interval_timer #(
    .ONE_HZ_DIV(DIV),
    .PRESC_W   (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start_timer  (start_timer),
    .interval_sel (interval_sel),
    .interval     (interval),
    .value        (value),
    .expired      (expired),
    .busy         (busy),
    .remaining    (remaining),
    .one_hz_enable(one_hz_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] val;
    int         rem1;       // remaining after E1
    int         exp_edge;   // edge index after which expired is high
    int         ticks;      // number of one_hz_enable pulses
    int         first_tick; // edge index after which the first pulse is seen
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [1:0] sel);
    start_timer  = 1'b1;
    interval_sel = sel;
    step();
    start_timer  = 1'b0;
  endtask

  // Step from edge k0 to one edge past exp_edge. Check a single expired pulse
  // at exp_edge, busy held until then, and idle afterwards.
  task automatic track(input int k0, input int exp_edge, input string tag);
    int seen;
    int cnt;
    int idle_early;
    seen       = -1;
    cnt        = 0;
    idle_early = 0;
    for (int k = k0 + 1; k <= exp_edge + 1; k++) begin
      step();
      if (expired) begin
        cnt++;
        if (seen < 0) seen = k;
      end
      if (k <= exp_edge && !busy) idle_early++;
    end
    check({tag, " expire edge"}, seen, exp_edge);
    check({tag, " expire count"}, cnt, 1);
    check({tag, " busy gaps"}, idle_early, 0);
    check({tag, " busy after"}, int'(busy), 0);
  endtask

  initial begin
    int seen;
    int cnt;
    int ticks;
    int first_tick;

    tests        = 0;
    fails        = 0;
    start_timer  = 1'b0;
    interval_sel = 2'b00;
    param_mem[0] = 4'd6;
    param_mem[1] = 4'd8;
    param_mem[2] = 4'd15;
    param_mem[3] = 4'd0;

    vecs[0] = '{sel: 2'b00, val: 4'd6,  rem1: 6,  exp_edge: 61,  ticks: 6,  first_tick: 10};
    vecs[1] = '{sel: 2'b11, val: 4'd0,  rem1: 0,  exp_edge: 1,   ticks: 0,  first_tick: -1};
    vecs[2] = '{sel: 2'b01, val: 4'd1,  rem1: 1,  exp_edge: 11,  ticks: 1,  first_tick: 10};
    vecs[3] = '{sel: 2'b10, val: 4'd15, rem1: 15, exp_edge: 151, ticks: 15, first_tick: 10};
    vecs[4] = '{sel: 2'b10, val: 4'd3,  rem1: 3,  exp_edge: 31,  ticks: 3,  first_tick: 10};

    // Reset state.
    reset = 1'b0;
    #12;
    check("rst interval", int'(interval), 0);
    check("rst expired", int'(expired), 0);
    check("rst busy", int'(busy), 0);
    check("rst remaining", int'(remaining), 0);
    check("rst one_hz", int'(one_hz_enable), 0);
    reset = 1'b1;
    step();
    check("idle busy", int'(busy), 0);

    // Table-driven full countdowns.
    for (int i = 0; i < 5; i++) begin
      param_mem[vecs[i].sel] = vecs[i].val;
      start(vecs[i].sel);
      check($sformatf("v%0d interval", i), int'(interval), int'(vecs[i].sel));
      check($sformatf("v%0d busy E0", i), int'(busy), 1);
      seen       = -1;
      cnt        = 0;
      ticks      = 0;
      first_tick = -1;
      for (int k = 1; k <= vecs[i].exp_edge + 1; k++) begin
        step();
        if (one_hz_enable) begin
          ticks++;
          if (first_tick < 0) first_tick = k;
        end
        if (expired) begin
          cnt++;
          if (seen < 0) seen = k;
        end
        if (k == 1)
          check($sformatf("v%0d rem E1", i), int'(remaining), vecs[i].rem1);
        if (k > 1 && k <= vecs[i].exp_edge && (k - 1) % DIV == 0)
          check($sformatf("v%0d rem E%0d", i, k), int'(remaining),
                int'(vecs[i].val) - (k - 1) / DIV);
      end
      check($sformatf("v%0d expire edge", i), seen, vecs[i].exp_edge);
      check($sformatf("v%0d expire count", i), cnt, 1);
      check($sformatf("v%0d ticks", i), ticks, vecs[i].ticks);
      check($sformatf("v%0d first tick", i), first_tick, vecs[i].first_tick);
      check($sformatf("v%0d busy end", i), int'(busy), 0);
      check($sformatf("v%0d rem end", i), int'(remaining), 0);
      step();
    end

    // Restart coinciding with the 3rd tick of a 15 s interval.
    param_mem[2] = 4'd15;
    param_mem[1] = 4'd8;
    start(2'b10);
    for (int k = 1; k <= 30; k++) step();
    check("t3 tick3 pulse", int'(one_hz_enable), 1);
    check("t3 rem before", int'(remaining), 13);
    start(2'b01);
    check("t3 interval", int'(interval), 1);
    check("t3 rem held", int'(remaining), 13);
    check("t3 no expire", int'(expired), 0);
    step();
    check("t3 rem reload", int'(remaining), 8);
    track(1, 81, "t3");
    step();

    // Reprogramming the parameter block mid-count has no effect.
    param_mem[1] = 4'd8;
    start(2'b01);
    for (int k = 1; k <= 5; k++) step();
    param_mem[1] = 4'd3;
    for (int k = 6; k <= 11; k++) step();
    check("t4 rem latched", int'(remaining), 7);
    track(11, 81, "t4");
    step();

    // Asynchronous reset mid-count with remaining = 4.
    param_mem[0] = 4'd6;
    start(2'b00);
    for (int k = 1; k <= 25; k++) step();
    check("t5 rem before", int'(remaining), 4);
    #2;
    reset = 1'b0;
    #1;
    check("t5 async busy", int'(busy), 0);
    check("t5 async rem", int'(remaining), 0);
    check("t5 async interval", int'(interval), 0);
    check("t5 async expired", int'(expired), 0);
    #3;
    reset = 1'b1;
    cnt = 0;
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (expired) cnt++;
      if (busy) seen++;
    end
    check("t5 no expire", cnt, 0);
    check("t5 stays idle", seen, 0);

    // Restart requested during the EXPIRE cycle.
    param_mem[0] = 4'd2;
    param_mem[3] = 4'd1;
    start(2'b00);
    for (int k = 1; k <= 21; k++) step();
    check("t6 expire", int'(expired), 1);
    check("t6 busy exp", int'(busy), 1);
    start(2'b11);
    check("t6 load no expire", int'(expired), 0);
    check("t6 busy load", int'(busy), 1);
    check("t6 interval", int'(interval), 3);
    track(0, 11, "t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
